// File: rtl/shift_window_ctrl.sv
// shift_window_ctrl: arbitrates a fifo_shift window register between an RX byte
// stream, a full-window batch loader and a TX drain. It tracks how many words
// are in the window and serialises the window to TX, oldest word first.
module shift_window_ctrl #(
  parameter int DATA_SIZE  = 8,
  parameter int ADDR_SPACE = 4,
  parameter int CNT_W      = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx_valid,
  input  logic [DATA_SIZE-1:0]            rx_data,
  output logic                            rx_ready,
  input  logic                            batch_req,
  input  logic [DATA_SIZE*ADDR_SPACE-1:0] batch_data,
  output logic                            batch_ack,
  input  logic                            drain_req,
  output logic                            drain_ack,
  output logic                            tx_valid,
  output logic [DATA_SIZE-1:0]            tx_data,
  input  logic                            tx_ready,
  output logic                            sr_write,
  output logic [DATA_SIZE-1:0]            sr_write_data,
  output logic                            sr_batch,
  output logic [DATA_SIZE*ADDR_SPACE-1:0] sr_batch_data,
  input  logic [DATA_SIZE-1:0]            sr_last,
  output logic [CNT_W-1:0]                fill_count,
  output logic                            window_full,
  output logic                            busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_BATCH     = 3'd1;
  localparam logic [2:0] S_DR_LOAD   = 3'd2;
  localparam logic [2:0] S_DR_WAIT   = 3'd3;
  localparam logic [2:0] S_DR_SHIFT  = 3'd4;
  localparam logic [2:0] S_DR_SETTLE = 3'd5;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(ADDR_SPACE);

  // Fill level saturates at the window depth; older words fall off the top.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == FULL) ? FULL : v + CNT_W'(1);
  endfunction

  logic [2:0]                      state_q, state_d;
  logic [CNT_W-1:0]                remaining_q, remaining_d;
  logic [CNT_W-1:0]                fill_q, fill_d;
  logic                            tx_valid_q, tx_valid_d;
  logic [DATA_SIZE-1:0]            tx_data_q, tx_data_d;
  logic                            sr_write_q, sr_write_d;
  logic [DATA_SIZE-1:0]            sr_write_data_q, sr_write_data_d;
  logic                            sr_batch_q, sr_batch_d;
  logic [DATA_SIZE*ADDR_SPACE-1:0] sr_batch_data_q, sr_batch_data_d;
  logic                            batch_ack_q, batch_ack_d;
  logic                            drain_ack_q, drain_ack_d;

  // RX is only taken when idle and no higher-priority requester is waiting;
  // gated by reset so every output reads 0 while reset is held.
  assign rx_ready = reset && (state_q == S_IDLE) && !batch_req && !drain_req;

  // Next-state and registered-output logic for the sequencer.
  always_comb begin
    state_d         = state_q;
    remaining_d     = remaining_q;
    fill_d          = fill_q;
    tx_valid_d      = tx_valid_q;
    tx_data_d       = tx_data_q;
    sr_write_d      = 1'b0;
    sr_write_data_d = '0;
    sr_batch_d      = 1'b0;
    sr_batch_data_d = sr_batch_data_q;
    batch_ack_d     = 1'b0;
    drain_ack_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (batch_req) begin
          state_d         = S_BATCH;
          sr_batch_d      = 1'b1;
          sr_batch_data_d = batch_data;
          batch_ack_d     = 1'b1;
          fill_d          = FULL;
        end else if (drain_req) begin
          state_d     = S_DR_LOAD;
          remaining_d = FULL;
        end else if (rx_valid) begin
          sr_write_d      = 1'b1;
          sr_write_data_d = rx_data;
          fill_d          = sat_inc(fill_q);
        end
      end
      S_BATCH: state_d = S_IDLE;
      S_DR_LOAD: begin
        tx_data_d  = sr_last;
        tx_valid_d = 1'b1;
        state_d    = S_DR_WAIT;
      end
      S_DR_WAIT: begin
        if (tx_ready) begin
          tx_valid_d      = 1'b0;
          remaining_d     = remaining_q - CNT_W'(1);
          sr_write_d      = 1'b1;
          sr_write_data_d = '0;
          state_d         = S_DR_SHIFT;
        end
      end
      // Shift pulse is already on sr_write; flag completion if this was the last word.
      S_DR_SHIFT: begin
        drain_ack_d = (remaining_q == '0);
        state_d     = S_DR_SETTLE;
      end
      S_DR_SETTLE: begin
        if (remaining_q != '0) begin
          state_d = S_DR_LOAD;
        end else begin
          fill_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset clears them but not the window itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      remaining_q     <= '0;
      fill_q          <= '0;
      tx_valid_q      <= 1'b0;
      tx_data_q       <= '0;
      sr_write_q      <= 1'b0;
      sr_write_data_q <= '0;
      sr_batch_q      <= 1'b0;
      sr_batch_data_q <= '0;
      batch_ack_q     <= 1'b0;
      drain_ack_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      fill_q          <= fill_d;
      tx_valid_q      <= tx_valid_d;
      tx_data_q       <= tx_data_d;
      sr_write_q      <= sr_write_d;
      sr_write_data_q <= sr_write_data_d;
      sr_batch_q      <= sr_batch_d;
      sr_batch_data_q <= sr_batch_data_d;
      batch_ack_q     <= batch_ack_d;
      drain_ack_q     <= drain_ack_d;
    end
  end

  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign sr_write      = sr_write_q;
  assign sr_write_data = sr_write_data_q;
  assign sr_batch      = sr_batch_q;
  assign sr_batch_data = sr_batch_data_q;
  assign batch_ack     = batch_ack_q;
  assign drain_ack     = drain_ack_q;
  assign fill_count    = fill_q;
  assign window_full   = (fill_q == FULL);
  assign busy          = (state_q != S_IDLE);

endmodule
